// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit multiply/divide engine owning the HI/LO
// registers. One result bit per cycle: shift-add multiply, restoring divide.
// Signed operations run on magnitudes; the sign is restored in FINISH.
//
//   state  | meaning
//   IDLE   | waiting for start; MTHI/MTLO execute here in one edge
//   CALC   | ITER iteration cycles, one product/quotient bit per cycle
//   FINISH | sign fix-up, HI/LO write, done pulse armed for next cycle
module mul_div_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_div;
  logic            b_zero;
  logic            neg_res;
  logic            neg_rem;
  logic [XLEN-1:0] a_raw;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  // acc is the product high half for multiply, partial remainder for divide;
  // qreg is the product low half / multiplier, or the dividend/quotient.
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] qreg;

  logic              is_signed;
  logic              is_muldiv;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     mstep;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  assign busy = (state != IDLE);

  // Operand conditioning and per-iteration datapath
  always_comb begin
    is_muldiv = ~op[2];
    is_signed = ~op[0];
    a_abs     = (is_signed && a[XLEN-1]) ? -a : a;
    b_abs     = (is_signed && b[XLEN-1]) ? -b : b;
    sum       = {1'b0, acc} + {1'b0, opa};
    mstep     = qreg[0] ? sum : {1'b0, acc};
    // Trial subtraction is 33 bits wide; a clear MSB means the divisor fits.
    shifted   = {acc, qreg[XLEN-1]};
    diff      = shifted - {1'b0, opb};
    prod      = {acc, qreg};
    prod_fix  = neg_res ? -prod : prod;
    quo_fix   = neg_res ? -qreg : qreg;
    rem_fix   = neg_rem ? -acc : acc;
  end

  // Sequencer, iteration registers and architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      b_zero  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      a_raw   <= '0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      qreg    <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_muldiv) begin
              is_div  <= op[1];
              b_zero  <= (b == '0);
              neg_res <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
              neg_rem <= is_signed & a[XLEN-1];
              a_raw   <= a;
              opa     <= a_abs;
              opb     <= b_abs;
              acc     <= '0;
              qreg    <= op[1] ? a_abs : b_abs;
              cnt     <= '0;
              state   <= CALC;
            end else if (op == 3'b100) begin
              hi <= a;
            end else if (op == 3'b101) begin
              lo <= a;
            end
          end
        end
        CALC: begin
          if (is_div) begin
            if (!diff[XLEN]) begin
              acc  <= diff[XLEN-1:0];
              qreg <= {qreg[XLEN-2:0], 1'b1};
            end else begin
              acc  <= shifted[XLEN-1:0];
              qreg <= {qreg[XLEN-2:0], 1'b0};
            end
          end else begin
            acc  <= mstep[XLEN:1];
            qreg <= {mstep[0], qreg[XLEN-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          if (is_div) begin
            // Divide by zero reports the untouched dividend and an all-ones quotient.
            if (b_zero) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            hi <= prod_fix[2*XLEN-1:XLEN];
            lo <= prod_fix[XLEN-1:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table of mul/div vectors through a scoreboard queue, plus
// hand sequences for MTHI/MTLO, ignored starts, back-to-back and mid-op reset.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at a negedge; drives start for one edge, then scrambles operands.
  task automatic launch(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] eh, input logic [31:0] el, input string name);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    sb.push_back('{eh, el, name});
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Starts at the negedge of the first busy cycle; returns at the done negedge.
  task automatic wait_done(input int exp_busy);
    int   nbusy;
    bit   seen;
    exp_t e;
    nbusy = 0;
    seen  = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
      if (n == 16) begin
        check32("hold_hi_during_calc", hi, cur_hi);
        check32("hold_lo_during_calc", lo, cur_lo);
      end
      @(negedge clk);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=no_done required=done_pulse");
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_done actual=done required=no_pending_op");
    end else begin
      e = sb.pop_front();
      check32({e.name, "_hi"}, hi, e.hi);
      check32({e.name, "_lo"}, lo, e.lo);
      check32({e.name, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
      check32({e.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      cur_hi = e.hi;
      cur_lo = e.lo;
    end
  endtask

  initial begin
    int seen_done;

    vecs.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"});
    vecs.push_back('{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7"});
    vecs.push_back('{3'b000, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, "mult_neg_neg"});
    vecs.push_back('{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minint_sq"});
    vecs.push_back('{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "multu_carry"});
    vecs.push_back('{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2"});
    vecs.push_back('{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_neg2"});
    vecs.push_back('{3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7"});
    vecs.push_back('{3'b011, 32'h00000055, 32'h00000000, 32'h00000055, 32'hFFFFFFFF, "divu_by_zero"});
    vecs.push_back('{3'b010, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, "div_neg_by_zero"});
    vecs.push_back('{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow"});
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, "divu_max_1"});

    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    cur_hi = '0;
    cur_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check32("reset_hi",   hi, 32'h0);
    check32("reset_lo",   lo, 32'h0);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_done", {31'd0, done}, 32'd0);

    // MTHI / MTLO complete at one edge without busy or done
    start = 1'b1; op = 3'b100; a = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    check32("mthi_hi",   hi, 32'h12345678);
    check32("mthi_lo",   lo, 32'h0);
    check32("mthi_busy", {31'd0, busy}, 32'd0);
    check32("mthi_done", {31'd0, done}, 32'd0);
    start = 1'b1; op = 3'b101; a = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0;
    check32("mtlo_lo",   lo, 32'hCAFEF00D);
    check32("mtlo_hi",   hi, 32'h12345678);
    check32("mtlo_busy", {31'd0, busy}, 32'd0);
    cur_hi = 32'h12345678;
    cur_lo = 32'hCAFEF00D;

    // Reserved opcode does nothing
    start = 1'b1; op = 3'b110; a = 32'hDEADBEEF; b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check32("nop_busy", {31'd0, busy}, 32'd0);
    check32("nop_hi", hi, cur_hi);
    check32("nop_lo", lo, cur_lo);

    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name);
      wait_done(33);
      @(negedge clk);
      check32({vecs[i].name, "_done_width"}, {31'd0, done}, 32'd0);
    end

    // Second start during CALC is ignored
    launch(3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_ignore_start");
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(28);
    @(negedge clk);
    check32("ignored_start_no_relaunch", {31'd0, busy}, 32'd0);

    // Back-to-back: start issued in the done cycle is accepted
    launch(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, "b2b_first");
    wait_done(33);
    launch(3'b001, 32'd6, 32'd7, 32'd0, 32'd42, "b2b_second");
    wait_done(33);

    // Reset during CALC cycle 10 aborts without HI/LO write or done
    @(negedge clk);
    launch(3'b000, 32'd5, 32'd5, 32'd0, 32'd25, "mult_aborted");
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    check32("abort_busy", {31'd0, busy}, 32'd0);
    check32("abort_hi", hi, 32'h0);
    check32("abort_lo", lo, 32'h0);
    check32("abort_done", {31'd0, done}, 32'd0);
    cur_hi = '0;
    cur_lo = '0;
    seen_done = 0;
    for (int n = 0; n < 40; n++) begin
      if (done || busy) seen_done = 1;
      @(negedge clk);
    end
    check32("abort_no_late_done", 32'(seen_done), 32'd0);
    launch(3'b011, 32'd9, 32'd3, 32'd0, 32'd3, "divu_after_reset");
    wait_done(33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
